fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Sits directly downstream of the warp scheduler and upstream of the instruction buffer/decode.
- Accepts one scheduled warp (wid, tmask, PC, uuid) per cycle and issues a tagged I-cache read.
- Stores per-warp request metadata and, on the I-cache response, emits the fetched instruction with its metadata.
- Enforces per-warp instruction-buffer credits so the scheduler never over-fills the instruction buffer.

Parameters:
NUM_WARPS, 4, warps per core; NW_WIDTH = max(1, clog2(NUM_WARPS))
NUM_THREADS, 4, threads per warp (tmask width)
PC_BITS, 31, PC width in 2-byte units
UUID_WIDTH, 44, instruction uuid width
IBUF_SIZE, 4, instruction-buffer entries per warp (credit limit)
ADDR_WIDTH, 30, I-cache word (4-byte) address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
sched_valid  in  1  scheduled warp valid
sched_ready  out  1  stage accepts schedule
sched_wid  in  NW_WIDTH  warp id
sched_tmask  in  NUM_THREADS  thread mask
sched_pc  in  PC_BITS  warp PC
sched_uuid  in  UUID_WIDTH  instruction uuid
icache_req_valid  out  1  read request valid
icache_req_ready  in  1  I-cache accepts request
icache_req_addr  out  ADDR_WIDTH  word address
icache_req_tag  out  NW_WIDTH  tag (equals wid)
icache_rsp_valid  in  1  response valid
icache_rsp_ready  out  1  response accepted
icache_rsp_data  in  32  instruction word
icache_rsp_tag  in  NW_WIDTH  response tag
fetch_valid  out  1  fetched instruction valid
fetch_ready  in  1  downstream accepts
fetch_wid  out  NW_WIDTH  warp id
fetch_tmask  out  NUM_THREADS  thread mask
fetch_pc  out  PC_BITS  PC
fetch_instr  out  32  instruction
fetch_uuid  out  UUID_WIDTH  uuid
ibuf_pop  in  1  instruction buffer released one entry
ibuf_pop_wid  in  NW_WIDTH  warp of released entry
busy  out  1  any request outstanding or request register occupied

Behaviour:
- Clock and reset: clk only; reset is synchronous, active-high.
- Reset values: all credit counters and pending bits are 0. The request register is empty. icache_req_valid, fetch_valid and busy are 0.
- Credits:
  - Per-warp counter ctr[w], width clog2(IBUF_SIZE+1).
  - Increments on schedule accept for that warp; decrements on ibuf_pop for that warp.
  - Increment and decrement for the same warp in the same cycle leave the counter unchanged.
  - full[w] = (ctr[w] == IBUF_SIZE).
- sched_ready = ~req_reg_valid_or_stalled & ~full[sched_wid] & ~pending[sched_wid].
  - req_reg_valid_or_stalled means the request register holds an entry and icache_req_ready is 0.
  - The request register is a one-entry pipeline register: it accepts a new entry in the same cycle the old one drains.
- Accept (sched_valid & sched_ready) at cycle T:
  - Writes {tmask, pc, uuid} into the per-warp metadata store at index wid.
  - Sets pending[wid].
  - Loads the request register.
  - icache_req_valid is asserted at T+1, with icache_req_addr = ADDR_WIDTH'(pc >> 1) and icache_req_tag = wid.
- The request holds stable while icache_req_valid & ~icache_req_ready.
- Response path is combinational:
  - fetch_valid = icache_rsp_valid; icache_rsp_ready = fetch_ready.
  - Metadata is read at index icache_rsp_tag; fetch_instr = icache_rsp_data.
  - On response fire, pending[tag] is cleared.
  - Minimum accept-to-output latency is 1 cycle plus the I-cache latency.
- Simultaneous events:
  - A response clearing pending[w] and a new accept for the same w in one cycle: the accept is blocked by the old pending value. The clear takes effect first, next cycle.
  - ibuf_pop when ctr == 0 triggers an assertion and saturates at 0.
  - A response with a tag that has no pending bit triggers an assertion.
- Ordering: at most one outstanding fetch per warp. Across warps, responses may return in any order.
- Reset mid-operation: all state is cleared. The I-cache is reset with this stage, so no stale responses are expected.
- busy = req_reg_valid | (pending != 0).

Decomposition:
- Shared package holds:
  - the fetch_t struct {wid, tmask, PC, uuid, instr};
  - the schedule_t struct {wid, tmask, PC, uuid};
  - the IBUF_SIZE constant.
- Natural sub-module: fetch_credit_ctr, holding the per-warp credit counters and full flags.
- The metadata store is a NUM_WARPS-deep register array inline, with one write port and one read port.

Test Plan:
- Single warp: schedule wid=0, pc=0x40, tmask=4'b0001, uuid=5. Expect icache_req_addr=0x20, tag=0, valid one cycle later. Respond with data 0x00000013. Expect fetch_instr=0x13, pc=0x40, uuid=5.
- Credit full: IBUF_SIZE=4, four fetches on wid=1 with no ibuf_pop. Expect sched_ready=0 for wid=1 and wid=2 still accepted. One ibuf_pop wid=1 re-enables sched_ready next cycle.
- Out-of-order responses: warps 0, 1, 2 requested with pcs 0x10, 0x20, 0x30. Respond with tags 2, 0, 1. Expect the output metadata to match each tag exactly.
- Back-pressure: icache_req_ready=0 for 5 cycles. Expect addr/tag stable and sched_ready=0. fetch_ready=0 holds icache_rsp_ready=0 and the output stable.
- Same-cycle pop and accept on wid=3 with ctr=2. Expect ctr to remain 2.
- Reset asserted with 2 requests pending. Next cycle expect busy=0, all sched_ready conditions satisfied, fetch_valid=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int NUM_WARPS_DEFAULT   = 4;
  localparam int NUM_THREADS_DEFAULT = 4;
  localparam int PC_BITS_DEFAULT     = 31;
  localparam int UUID_WIDTH_DEFAULT  = 44;
  localparam int IBUF_SIZE_DEFAULT   = 4;
  localparam int ADDR_WIDTH_DEFAULT  = 30;
  localparam int NW_WIDTH_DEFAULT    = (NUM_WARPS_DEFAULT > 1) ? $clog2(NUM_WARPS_DEFAULT) : 1;

  typedef struct packed {
    logic [NW_WIDTH_DEFAULT-1:0]    wid;
    logic [NUM_THREADS_DEFAULT-1:0] tmask;
    logic [PC_BITS_DEFAULT-1:0]     pc;
    logic [UUID_WIDTH_DEFAULT-1:0]  uuid;
  } schedule_t;

  typedef struct packed {
    logic [NW_WIDTH_DEFAULT-1:0]    wid;
    logic [NUM_THREADS_DEFAULT-1:0] tmask;
    logic [PC_BITS_DEFAULT-1:0]     pc;
    logic [UUID_WIDTH_DEFAULT-1:0]  uuid;
    logic [31:0]                    instr;
  } fetch_t;

endpackage

// File: rtl/fetch_stage_credit_ctr.sv
// Per-warp instruction-buffer credit counters; full[w] blocks further scheduling of warp w.
module fetch_credit_ctr
  import fetch_stage_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_DEFAULT,
  parameter int IBUF_SIZE = IBUF_SIZE_DEFAULT,
  parameter int NW_WIDTH  = NW_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic [NW_WIDTH-1:0]  inc_wid,
  input  logic                 dec,
  input  logic [NW_WIDTH-1:0]  dec_wid,
  output logic [NUM_WARPS-1:0] full
);

  localparam int CTR_W = $clog2(IBUF_SIZE + 1);
  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(IBUF_SIZE);
  localparam logic [CTR_W-1:0] ONE   = CTR_W'(1);

  logic [CTR_W-1:0]     ctr [NUM_WARPS];
  logic [NUM_WARPS-1:0] up;
  logic [NUM_WARPS-1:0] dn;

  always_comb begin
    up   = '0;
    dn   = '0;
    full = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      up[w]   = inc & (inc_wid == NW_WIDTH'(w));
      dn[w]   = dec & (dec_wid == NW_WIDTH'(w));
      full[w] = (ctr[w] == LIMIT);
    end
  end

  // A simultaneous credit take and release cancel out; a release at zero saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) ctr[w] <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (up[w] & ~dn[w])
          ctr[w] <= ctr[w] + ONE;
        else if (dn[w] & ~up[w] & (ctr[w] != '0))
          ctr[w] <= ctr[w] - ONE;
      end
    end
  end

  pop_underflow: assert property (@(posedge clk) disable iff (reset)
    dec |-> (ctr[dec_wid] != '0));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: issues tagged I-cache reads for scheduled warps and pairs responses with stored metadata.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter  int NUM_WARPS   = NUM_WARPS_DEFAULT,
  parameter  int NUM_THREADS = NUM_THREADS_DEFAULT,
  parameter  int PC_BITS     = PC_BITS_DEFAULT,
  parameter  int UUID_WIDTH  = UUID_WIDTH_DEFAULT,
  parameter  int IBUF_SIZE   = IBUF_SIZE_DEFAULT,
  parameter  int ADDR_WIDTH  = ADDR_WIDTH_DEFAULT,
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [PC_BITS-1:0]     sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [ADDR_WIDTH-1:0]  icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,
  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [31:0]            icache_rsp_data,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [PC_BITS-1:0]     fetch_pc,
  output logic [31:0]            fetch_instr,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  input  logic                   ibuf_pop,
  input  logic [NW_WIDTH-1:0]    ibuf_pop_wid,
  output logic                   busy
);

  typedef struct packed {
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_BITS-1:0]     pc;
    logic [UUID_WIDTH-1:0]  uuid;
  } meta_t;

  logic [NUM_WARPS-1:0]  pending;
  logic [NUM_WARPS-1:0]  full;
  logic                  req_stall;
  logic                  sched_fire;
  logic                  rsp_fire;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] req_addr_p1;
  logic [NW_WIDTH-1:0]   req_tag_p1;
  meta_t                 meta_mem [NUM_WARPS];
  meta_t                 meta_rd;

  assign req_stall   = vld_p1 & ~icache_req_ready;
  assign sched_ready = ~req_stall & ~full[sched_wid] & ~pending[sched_wid];
  assign sched_fire  = sched_valid & sched_ready;
  assign rsp_fire    = icache_rsp_valid & fetch_ready;

  fetch_credit_ctr #(
    .NUM_WARPS (NUM_WARPS),
    .IBUF_SIZE (IBUF_SIZE),
    .NW_WIDTH  (NW_WIDTH)
  ) u_credit (
    .clk     (clk),
    .reset   (reset),
    .inc     (sched_fire),
    .inc_wid (sched_wid),
    .dec     (ibuf_pop),
    .dec_wid (ibuf_pop_wid),
    .full    (full)
  );

  // p0 -> p1: accepted schedule loads the request register and the metadata store
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (rsp_fire)
        pending[icache_rsp_tag] <= 1'b0;
      if (sched_fire)
        pending[sched_wid] <= 1'b1;
      if (sched_fire)
        vld_p1 <= 1'b1;
      else if (icache_req_ready)
        vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sched_fire) begin
      req_addr_p1         <= ADDR_WIDTH'(sched_pc >> 1);
      req_tag_p1          <= sched_wid;
      meta_mem[sched_wid] <= '{tmask: sched_tmask, pc: sched_pc, uuid: sched_uuid};
    end
  end

  assign icache_req_valid = vld_p1;
  assign icache_req_addr  = req_addr_p1;
  assign icache_req_tag   = req_tag_p1;

  // response side: metadata lookup by tag, no register stage
  assign meta_rd          = meta_mem[icache_rsp_tag];
  assign fetch_valid      = icache_rsp_valid;
  assign icache_rsp_ready = fetch_ready;
  assign fetch_wid        = icache_rsp_tag;
  assign fetch_tmask      = meta_rd.tmask;
  assign fetch_pc         = meta_rd.pc;
  assign fetch_uuid       = meta_rd.uuid;
  assign fetch_instr      = icache_rsp_data;

  assign busy = vld_p1 | (|pending);

  rsp_without_request: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> pending[icache_rsp_tag]);

endmodule
